// File: rtl/pcie_tag_pkg.sv
// Shared constants and tag-state encoding for the PCIe
// non-posted tag scheduler and the endpoint.
package pcie_tag_pkg;

  localparam int NUM_TAGS_DEF = 32;
  localparam int TAG_W_DEF    = 8;
  localparam int HDR_W_DEF    = 32;

  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;

  typedef enum logic {
    TAG_FREE = 1'b0,
    TAG_BUSY = 1'b1
  } tag_state_e;

endpackage

// File: rtl/pcie_tag_scheduler_if.sv
// Request, TX and completion bundle between the requesters,
// the tag scheduler and the endpoint TX path.
interface pcie_tag_scheduler_if #(
  parameter int TAG_W = 8,
  parameter int HDR_W = 32
);

  logic [1:0]       req_valid;
  logic [HDR_W-1:0] req0_header;
  logic [HDR_W-1:0] req1_header;
  logic [1:0]       req_ready;

  logic             tx_valid;
  logic [HDR_W-1:0] tx_header;
  logic [TAG_W-1:0] tx_tag;
  logic             tx_ready;

  logic             cpl_valid;
  logic [TAG_W-1:0] cpl_tag;
  logic             cpl_last;
  logic             cpl_owner_valid;
  logic             cpl_owner;
  logic             cpl_err;

  logic [TAG_W:0]   outstanding;
  logic             tags_full;

  modport slave (
    input  req_valid, req0_header, req1_header,
    input  tx_ready,
    input  cpl_valid, cpl_tag, cpl_last,
    output req_ready,
    output tx_valid, tx_header, tx_tag,
    output cpl_owner_valid, cpl_owner, cpl_err,
    output outstanding, tags_full
  );

  modport master (
    output req_valid, req0_header, req1_header,
    output tx_ready,
    output cpl_valid, cpl_tag, cpl_last,
    input  req_ready,
    input  tx_valid, tx_header, tx_tag,
    input  cpl_owner_valid, cpl_owner, cpl_err,
    input  outstanding, tags_full
  );

endinterface

// File: rtl/pcie_tag_freelist.sv
// Tag state bitmap with a lowest-free priority encoder
// and an allocated-tag counter.
module pcie_tag_freelist
  import pcie_tag_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  input  logic [TAG_W-1:0] query_tag,
  output logic [TAG_W-1:0] free_tag,
  output logic             any_free,
  output logic             query_busy,
  output logic [TAG_W:0]   count
);

  tag_state_e     state_q [NUM_TAGS];
  tag_state_e     state_d [NUM_TAGS];
  logic [TAG_W:0] count_q;
  logic [TAG_W:0] count_d;

  // Downward scan so the last hit is the lowest index.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (state_q[i] == TAG_FREE) begin
        free_tag = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    query_busy = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (query_tag == TAG_W'(i) &&
          state_q[i] == TAG_BUSY) begin
        query_busy = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc && free_tag == TAG_W'(i)) begin
        state_d[i] = TAG_BUSY;
      end
      if (rel_valid && rel_tag == TAG_W'(i)) begin
        state_d[i] = TAG_FREE;
      end
    end
    count_d = count_q
            + {{TAG_W{1'b0}}, alloc}
            - {{TAG_W{1'b0}}, rel_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_q[i] <= TAG_FREE;
      end
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pcie_tag_scheduler.sv
// Round-robin sharing of the non-posted tag pool between two
// requesters, with a registered TX slot and completion routing.
module pcie_tag_scheduler
  import pcie_tag_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int HDR_W    = HDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pcie_tag_scheduler_if.slave  bus
);

  logic             rr_q, rr_d;
  logic             tx_valid_q, tx_valid_d;
  logic [HDR_W-1:0] tx_header_q, tx_header_d;
  logic [TAG_W-1:0] tx_tag_q, tx_tag_d;
  logic             cpl_ov_q, cpl_ov_d;
  logic             cpl_owner_q, cpl_owner_d;
  logic             cpl_err_q, cpl_err_d;
  logic             owner_q [NUM_TAGS];
  logic             owner_d [NUM_TAGS];

  logic             slot_open;
  logic             grant;
  logic             win;
  logic             cpl_hit;
  logic             rel_valid;
  logic             owner_rd;
  logic [TAG_W-1:0] free_tag;
  logic             any_free;
  logic             query_busy;
  logic [TAG_W:0]   count;

  pcie_tag_freelist #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_freelist (
    .clk        (clk),
    .reset      (reset),
    .alloc      (grant),
    .rel_valid  (rel_valid),
    .rel_tag    (bus.cpl_tag),
    .query_tag  (bus.cpl_tag),
    .free_tag   (free_tag),
    .any_free   (any_free),
    .query_busy (query_busy),
    .count      (count)
  );

  assign slot_open = !tx_valid_q || bus.tx_ready;
  assign grant     = slot_open && any_free && (|bus.req_valid);
  assign cpl_hit   = bus.cpl_valid && query_busy;
  assign rel_valid = cpl_hit && bus.cpl_last;

  always_comb begin
    unique case (bus.req_valid)
      2'b11:   win = rr_q;
      2'b10:   win = RQ1;
      default: win = RQ0;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    if (grant) begin
      bus.req_ready = (win == RQ1) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    owner_rd = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (bus.cpl_tag == TAG_W'(i)) begin
        owner_rd = owner_q[i];
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    tx_valid_d  = tx_valid_q;
    tx_header_d = tx_header_q;
    tx_tag_d    = tx_tag_q;
    owner_d     = owner_q;
    if (grant) begin
      rr_d        = ~rr_q;
      tx_valid_d  = 1'b1;
      tx_header_d = (win == RQ1) ? bus.req1_header
                                 : bus.req0_header;
      tx_tag_d    = free_tag;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (free_tag == TAG_W'(i)) begin
          owner_d[i] = win;
        end
      end
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_comb begin
    cpl_ov_d    = cpl_hit;
    cpl_owner_d = cpl_hit ? owner_rd : cpl_owner_q;
    cpl_err_d   = bus.cpl_valid && !cpl_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= RQ0;
      tx_valid_q  <= 1'b0;
      tx_header_q <= '0;
      tx_tag_q    <= '0;
      cpl_ov_q    <= 1'b0;
      cpl_owner_q <= 1'b0;
      cpl_err_q   <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        owner_q[i] <= 1'b0;
      end
    end else begin
      rr_q        <= rr_d;
      tx_valid_q  <= tx_valid_d;
      tx_header_q <= tx_header_d;
      tx_tag_q    <= tx_tag_d;
      cpl_ov_q    <= cpl_ov_d;
      cpl_owner_q <= cpl_owner_d;
      cpl_err_q   <= cpl_err_d;
      owner_q     <= owner_d;
    end
  end

  assign bus.tx_valid        = tx_valid_q;
  assign bus.tx_header       = tx_header_q;
  assign bus.tx_tag          = tx_tag_q;
  assign bus.cpl_owner_valid = cpl_ov_q;
  assign bus.cpl_owner       = cpl_owner_q;
  assign bus.cpl_err         = cpl_err_q;
  assign bus.outstanding     = count;
  assign bus.tags_full       =
    (count == (TAG_W + 1)'(NUM_TAGS));

endmodule

// File: tb/tb_pcie_tag_scheduler.sv
// Directed bench for pcie_tag_scheduler with a cycle model
// and hand-computed literal checkpoints.
module tb_pcie_tag_scheduler;

  localparam int NT = 32;
  localparam int TW = 8;
  localparam int HW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  pcie_tag_scheduler_if #(.TAG_W(TW), .HDR_W(HW)) bus ();

  pcie_tag_scheduler #(
    .NUM_TAGS (NT),
    .TAG_W    (TW),
    .HDR_W    (HW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: tag ownership table plus the expected registered outputs.
  bit          m_ok = 0;
  bit          m_busy [NT];
  bit          m_owner [NT];
  bit          m_ptr;
  bit          m_txv;
  bit [HW-1:0] m_txh;
  int          m_txt;
  bit          m_cov;
  bit          m_cown;
  bit          m_cerr;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NT; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit [1:0] m_ready();
    if (m_txv && !bus.tx_ready) return 2'b00;
    if (m_count() >= NT || bus.req_valid == 2'b00) return 2'b00;
    if (bus.req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return bus.req_valid;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1;
      for (int i = 0; i < NT; i++) begin
        m_busy[i] = 0;
        m_owner[i] = 0;
      end
      m_ptr = 0; m_txv = 0; m_txh = '0; m_txt = 0;
      m_cov = 0; m_cown = 0; m_cerr = 0;
    end else if (m_ok) begin
      bit [1:0] rdy;
      bit hit;
      int t;
      rdy = m_ready();
      t = int'(bus.cpl_tag);
      hit = bus.cpl_valid && t < NT && m_busy[t];
      m_cov = hit;
      m_cerr = bus.cpl_valid && !hit;
      if (hit) m_cown = m_owner[t];
      if (hit && bus.cpl_last) m_busy[t] = 0;
      if (rdy != 2'b00) begin
        int f;
        f = m_lowest();
        m_txv = 1;
        m_txh = rdy[1] ? bus.req1_header : bus.req0_header;
        m_txt = f;
        m_busy[f] = 1;
        m_owner[f] = rdy[1];
        m_ptr = ~m_ptr;
      end else if (bus.tx_ready) begin
        m_txv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_req_ready", bus.req_ready, m_ready());
      chk("m_tx_valid", bus.tx_valid, m_txv);
      if (m_txv) begin
        chk("m_tx_header", bus.tx_header, m_txh);
        chk("m_tx_tag", bus.tx_tag, m_txt);
      end
      chk("m_cpl_owner_valid", bus.cpl_owner_valid, m_cov);
      if (m_cov) chk("m_cpl_owner", bus.cpl_owner, m_cown);
      chk("m_cpl_err", bus.cpl_err, m_cerr);
      chk("m_outstanding", bus.outstanding, m_count());
      chk("m_tags_full", bus.tags_full, m_count() == NT);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic fill_all();
    bus.req_valid = 2'b11;
    for (int k = 0; k < NT; k++) begin
      bus.req0_header = 32'hA000_0000 | k;
      bus.req1_header = 32'hB000_0000 | k;
      step();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic cpl(int tag, bit last);
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = TW'(tag);
    bus.cpl_last  = last;
    step();
    bus.cpl_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.req0_header = '0;
    bus.req1_header = '0;
    bus.tx_ready = 1'b1;
    bus.cpl_valid = 1'b0;
    bus.cpl_tag = '0;
    bus.cpl_last = 1'b0;
    do_reset();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_tags_full", bus.tags_full, 0);
    chk("rst_cpl_err", bus.cpl_err, 0);

    // Single requester grant.
    bus.req_valid = 2'b01;
    bus.req0_header = 32'hAAAA_0001;
    #1;
    chk("t1_req_ready", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    chk("t1_tx_valid", bus.tx_valid, 1);
    chk("t1_tx_tag", bus.tx_tag, 0);
    chk("t1_tx_header", bus.tx_header, 32'hAAAA_0001);
    chk("t1_outstanding", bus.outstanding, 1);
    step();

    // Round-robin with both valid.
    do_reset();
    bus.req0_header = 32'h0000_00A0;
    bus.req1_header = 32'h0000_00B1;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_req_ready", bus.req_ready, k[0] ? 2'b10 : 2'b01);
      step();
      chk("t2_tx_tag", bus.tx_tag, k);
      chk("t2_tx_header", bus.tx_header,
          k[0] ? 32'h0000_00B1 : 32'h0000_00A0);
    end
    bus.req_valid = 2'b00;
    chk("t2_outstanding", bus.outstanding, 4);
    step();

    // TX back-pressure holds the slot.
    do_reset();
    bus.tx_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req0_header = 32'h1234_5678;
    step();
    bus.req0_header = 32'h9999_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_req_ready", bus.req_ready, 2'b00);
      step();
      chk("t3_tx_valid", bus.tx_valid, 1);
      chk("t3_tx_tag", bus.tx_tag, 0);
      chk("t3_tx_header", bus.tx_header, 32'h1234_5678);
      chk("t3_outstanding", bus.outstanding, 1);
    end
    bus.tx_ready = 1'b1;
    step();
    bus.req_valid = 2'b00;
    chk("t3_drain_tag", bus.tx_tag, 1);
    chk("t3_drain_hdr", bus.tx_header, 32'h9999_0000);

    // Fill the pool, then free tag 5 and regrant it.
    do_reset();
    fill_all();
    bus.req_valid = 2'b11;
    #1;
    chk("t4_full", bus.tags_full, 1);
    chk("t4_full_ready", bus.req_ready, 2'b00);
    cpl(5, 1'b1);
    chk("t4_cpl_ov", bus.cpl_owner_valid, 1);
    chk("t4_cpl_owner", bus.cpl_owner, 1);
    chk("t4_outstanding", bus.outstanding, 31);
    step();
    bus.req_valid = 2'b00;
    chk("t4_regrant_tag", bus.tx_tag, 5);
    chk("t4_refull", bus.outstanding, 32);

    // Partial then final completion for tag 7.
    cpl(7, 1'b0);
    chk("t5_ov1", bus.cpl_owner_valid, 1);
    chk("t5_owner1", bus.cpl_owner, 1);
    chk("t5_still_full", bus.tags_full, 1);
    cpl(7, 1'b1);
    chk("t5_ov2", bus.cpl_owner_valid, 1);
    chk("t5_owner2", bus.cpl_owner, 1);
    chk("t5_outstanding", bus.outstanding, 31);
    bus.req_valid = 2'b01;
    #1;
    chk("t5_ready", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    chk("t5_regrant_tag", bus.tx_tag, 7);

    // Mid-operation reset, then stale and out-of-range tags.
    do_reset();
    chk("t6_rst_out", bus.outstanding, 0);
    cpl(9, 1'b1);
    chk("t6_err", bus.cpl_err, 1);
    chk("t6_err_ov", bus.cpl_owner_valid, 0);
    chk("t6_err_out", bus.outstanding, 0);
    step();
    chk("t6_err_pulse", bus.cpl_err, 0);
    cpl(40, 1'b1);
    chk("t6_range_err", bus.cpl_err, 1);
    step();

    // Same-cycle grant and release with one tag free.
    fill_all();
    cpl(3, 1'b1);
    chk("t7_out31", bus.outstanding, 31);
    bus.req_valid = 2'b01;
    bus.req0_header = 32'hC0DE_0003;
    bus.cpl_valid = 1'b1;
    bus.cpl_tag = TW'(10);
    bus.cpl_last = 1'b1;
    #1;
    chk("t7_ready", bus.req_ready, 2'b01);
    step();
    bus.cpl_valid = 1'b0;
    bus.req_valid = 2'b00;
    chk("t7_tag", bus.tx_tag, 3);
    chk("t7_out_same", bus.outstanding, 31);
    chk("t7_owner", bus.cpl_owner, 0);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("t7_tag_next", bus.tx_tag, 10);
    chk("t7_out_full", bus.outstanding, 32);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_tag_scheduler.md
Name: pcie_tag_scheduler

Overview:
- Shares the endpoint's non-posted-read tag pool between two requesters (RQ0, RQ1) through a round-robin arbiter.
- Allocates the lowest free tag, tracks each tag's owner, and forwards the granted header plus tag to the TLP transmit stage through one registered output slot.
- Frees tags on the final completion and routes each completion back to its owning requester.
- Sits between the request sources and the endpoint TX path.

Parameters:
NUM_TAGS, 32, tag pool size; 2..256, and must not exceed 2**TAG_W
TAG_W, 8, tag field width
HDR_W, 32, TLP header width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  request valid, bit i = requester i
req0_header  in  HDR_W  requester 0 header
req1_header  in  HDR_W  requester 1 header
req_ready  out  2  request accepted this cycle (combinational)
tx_valid  out  1  header and tag presented to TX
tx_header  out  HDR_W  granted header
tx_tag  out  TAG_W  allocated tag
tx_ready  in  1  TX accepts
cpl_valid  in  1  completion arriving
cpl_tag  in  TAG_W  completion tag
cpl_last  in  1  final completion for the tag
cpl_owner_valid  out  1  registered completion route valid
cpl_owner  out  1  owning requester of the completed tag
cpl_err  out  1  one-cycle pulse: completion for an unallocated tag
outstanding  out  TAG_W+1  number of allocated tags
tags_full  out  1  outstanding == NUM_TAGS

Behaviour:
- Reset (synchronous, active-high): all of the following clear to 0 on the next clk edge:
  - outputs tx_valid, tx_header, tx_tag, cpl_owner_valid, cpl_owner, cpl_err, outstanding, tags_full
  - internal state: free bitmap (all free), owner array, round-robin pointer (RQ0 first)
- Reset mid-operation drops every outstanding tag and any pending TX slot. Completions arriving afterwards for old tags raise cpl_err.
- A slot is open when (!tx_valid || tx_ready).
- A grant is possible when the slot is open, at least one tag is free (using the pre-update bitmap) and at least one req_valid is high.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by the round-robin pointer wins. After every grant the pointer moves to the other requester.
  - req_ready is one-hot, or zero when no grant is possible.
- Acceptance in cycle N: tx_valid=1 in N+1, with tx_header = the winner's header and tx_tag = the lowest-index free tag. That tag is marked busy and its owner recorded in N+1.
- TX hold: tx_valid, tx_header and tx_tag stay stable until tx_ready=1. A new grant may load the slot in the same cycle the old entry drains (back-to-back, one per cycle).
- Completion (cpl_valid=1), with the tag busy:
  - In the next cycle: cpl_owner_valid=1 and cpl_owner = the stored owner.
  - If cpl_last=1, the tag is freed at the same edge.
- Completion for a free tag, or a tag >= NUM_TAGS: cpl_err=1 for one cycle, cpl_owner_valid=0, no state change.
- Same-cycle allocate and release:
  - The allocation uses the pre-release bitmap, so a tag freed in cycle N cannot be reissued before N+1.
  - outstanding = outstanding + alloc - release. Simultaneous alloc and release leaves it unchanged.
- Full: when tags_full=1, req_ready=0. A release in cycle N allows a grant in N+1.
- Order: the TX path is in order; completions may return in any order.
- Width rules: outstanding counts to NUM_TAGS without wrap. The tag index is zero-extended to TAG_W.

Decomposition:
- Package pcie_tag_pkg holds:
  - requester-id constants RQ0=0, RQ1=1
  - default NUM_TAGS and TAG_W
  - a tag-state encoding shared with the endpoint
- One sub-module, pcie_tag_freelist: bitmap plus a lowest-free priority encoder, with alloc/release ports, free_tag, any_free and count outputs.
- The arbiter, TX slot and completion routing stay in the top level.

Test Plan:
- Reset, then RQ0 valid with header 0xAAAA0001 and tx_ready=1 -> req_ready=01; next cycle tx_valid=1, tx_tag=0, tx_header=0xAAAA0001; outstanding=1.
- Both requesters valid for 4 cycles, tx_ready=1 -> grants in order RQ0, RQ1, RQ0, RQ1 with tags 0, 1, 2, 3; outstanding=4.
- tx_ready=0 for 3 cycles while requests are pending -> tx_valid, tx_header and tx_tag stay stable, no further grants; outstanding +1 only.
- Fill all 32 tags -> tags_full=1 and req_ready=00. cpl_valid with cpl_tag=5, cpl_last=1 -> next cycle cpl_owner_valid=1 with the stored owner; the following grant receives tag 5.
- cpl_tag=7 with cpl_last=0, then cpl_last=1 -> both completions route to the owner; tag 7 is freed only after the second.
- Completion for free tag 9 -> cpl_err=1 for one cycle, outstanding unchanged. Same-cycle grant and release with one tag free -> outstanding unchanged, the freed tag is not reused that cycle.
